nibble_frame_packer: RTL and testbench

Serial-to-parallel loader for the 128-operand nibble adder tree. Accepts one 4-bit operand per cycle on a valid/ready stream and packs operand k into frame bits [4k+3:4k]. Presents the completed 512-bit frame to the adder tree with a valid/ready handoff. Supports short frames via in_last, with the unused tail zero-filled.

---
 rtl/nibble_frame_packer_if.sv | 26 ++
 rtl/nibble_frame_packer.sv | 101 ++++++++++
 tb/tb_nibble_frame_packer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/nibble_frame_packer_if.sv
// rtl/nibble_frame_packer_if.sv - operand stream and frame handoff bundle for nibble_frame_packer
// master = operand source / adder-tree side, slave = the packer.
interface nibble_frame_packer_if #(
  parameter int NIBBLES = 128,
  parameter int CNT_W   = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [3:0]             in_data;
  logic                   in_last;
  logic [4*NIBBLES-1:0]   arr_out;
  logic                   arr_valid;
  logic                   arr_ready;
  logic [CNT_W-1:0]       fill_cnt;
  logic [11:0]            ref_sum;

  modport master (
    output in_valid, in_data, in_last, arr_ready,
    input  in_ready, arr_out, arr_valid, fill_cnt, ref_sum
  );

  modport slave (
    input  in_valid, in_data, in_last, arr_ready,
    output in_ready, arr_out, arr_valid, fill_cnt, ref_sum
  );
endinterface

// File: rtl/nibble_frame_packer.sv
// rtl/nibble_frame_packer.sv - packs 4-bit operands into a 4*NIBBLES-bit frame for the nibble adder tree
// Optional RUNNING_SUM_EN adds a running operand sum on ref_sum (tied to zero otherwise).
module nibble_frame_packer #(
  parameter int NIBBLES = 128,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_frame_packer_if.slave  bus
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 ready;
  logic                 valid;
  logic                 accept;
  logic                 close;
  logic                 handoff;
  logic [4*NIBBLES-1:0] frame;
  logic [CNT_W-1:0]     cnt;

  assign accept  = bus.in_valid && (state == FILL);
  assign close   = bus.in_last || (cnt == CNT_W'(NIBBLES - 1));
  assign handoff = (state == HOLD) && bus.arr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    valid      = 1'b0;
    case (state)
      FILL: begin
        ready = 1'b1;
        if (accept && close) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        valid = 1'b1;
        if (bus.arr_ready) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Clearing the whole frame at handoff is what zero-fills the tail of short frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame <= '0;
      cnt   <= '0;
    end else if (handoff) begin
      frame <= '0;
      cnt   <= '0;
    end else if (accept) begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (cnt == CNT_W'(k)) begin
          frame[4*k +: 4] <= bus.in_data;
        end
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef RUNNING_SUM_EN
  logic [11:0] sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (handoff) begin
      sum <= '0;
    end else if (accept) begin
      sum <= sum + {8'd0, bus.in_data};
    end
  end

  assign bus.ref_sum = sum;
`else
  assign bus.ref_sum = 12'd0;
`endif

  assign bus.in_ready  = ready;
  assign bus.arr_valid = valid;
  assign bus.arr_out   = frame;
  assign bus.fill_cnt  = cnt;

endmodule

// File: tb/tb_nibble_frame_packer.sv
// tb/tb_nibble_frame_packer.sv - directed self-checking bench for nibble_frame_packer
module tb_nibble_frame_packer;
  localparam int NIBBLES = 128;
  localparam int CNT_W   = 8;
  localparam int W       = 4 * NIBBLES;
`ifdef RUNNING_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_frame_packer_if #(.NIBBLES(NIBBLES), .CNT_W(CNT_W)) bus ();

  nibble_frame_packer #(.NIBBLES(NIBBLES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_arr;
  logic [W-1:0] frame_a;
  logic [W-1:0] frame_b;
  int           cyc_a;
  int           cyc_b;
  int           nframes;
  int           idx;
  int           exp_sum;
  logic         rdy;

  function automatic int tree_sum(input logic [W-1:0] a);
    int s = 0;
    for (int k = 0; k < NIBBLES; k++) s += int'(a[4*k +: 4]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.in_last   = 1'b0;
    bus.arr_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_arr_out",   bus.arr_out,   '0);
    chk("reset_fill_cnt",  W'(bus.fill_cnt), W'(0));
    chk("reset_in_ready",  W'(bus.in_ready), W'(1));
    chk("reset_arr_valid", W'(bus.arr_valid), W'(0));
    chk("reset_ref_sum",   W'(bus.ref_sum), W'(0));
    #1 rst = 1'b0;
    tick();

    // Reset mid-frame: 5 operands, then async reset with no clock edge.
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.in_data = 4'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mid_fill_cnt", W'(bus.fill_cnt), W'(5));
    chk("mid_arr_out",  bus.arr_out, W'(20'h54321));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_arr_out",   bus.arr_out, '0);
    chk("async_rst_fill_cnt",  W'(bus.fill_cnt), W'(0));
    chk("async_rst_in_ready",  W'(bus.in_ready), W'(1));
    chk("async_rst_arr_valid", W'(bus.arr_valid), W'(0));
    #1 rst = 1'b0;
    tick();

    // Short frame 3,7,9 with in_last on 9.
    bus.arr_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data = 4'd3; tick();
    bus.in_data = 4'd7; tick();
    bus.in_data = 4'd9; bus.in_last = 1'b1; tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("short_arr_valid", W'(bus.arr_valid), W'(1));
    chk("short_in_ready",  W'(bus.in_ready), W'(0));
    chk("short_arr_out",   bus.arr_out, W'(12'h973));
    chk("short_fill_cnt",  W'(bus.fill_cnt), W'(3));
    chk("short_tree_sum",  W'(tree_sum(bus.arr_out)), W'(19));
    chk("short_ref_sum",   W'(bus.ref_sum), W'(SUM_EN ? 19 : 0));
    bus.arr_ready = 1'b1;
    tick();
    chk("short_handoff_in_ready",  W'(bus.in_ready), W'(1));
    chk("short_handoff_arr_valid", W'(bus.arr_valid), W'(0));
    chk("short_handoff_arr_out",   bus.arr_out, '0);
    chk("short_handoff_fill_cnt",  W'(bus.fill_cnt), W'(0));
    bus.arr_ready = 1'b0;

    // Backpressure: frame held for 10 cycles with in_valid asserted.
    bus.in_valid = 1'b1;
    bus.in_data = 4'hA; tick();
    bus.in_data = 4'hB; bus.in_last = 1'b1; tick();
    bus.in_last = 1'b0;
    bus.in_data = 4'h5;
    for (int i = 0; i < 10; i++) begin
      chk("bp_in_ready", W'(bus.in_ready), W'(0));
      chk("bp_arr_out",  bus.arr_out, W'(8'hBA));
      tick();
    end
    chk("bp_fill_cnt", W'(bus.fill_cnt), W'(2));
    bus.arr_ready = 1'b1;
    tick();
    chk("bp_handoff_fill_cnt", W'(bus.fill_cnt), W'(0));
    chk("bp_handoff_in_ready", W'(bus.in_ready), W'(1));
    bus.arr_ready = 1'b0;
    tick();
    chk("bp_next_fill_cnt", W'(bus.fill_cnt), W'(1));
    chk("bp_next_arr_out",  bus.arr_out, W'(4'h5));
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    tick();

    // Full frame of 4'hF with arr_ready held high.
    bus.arr_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'hF;
    repeat (NIBBLES) tick();
    bus.in_valid = 1'b0;
    chk("full_arr_valid", W'(bus.arr_valid), W'(1));
    chk("full_arr_out",   bus.arr_out, '1);
    chk("full_fill_cnt",  W'(bus.fill_cnt), W'(128));
    chk("full_tree_sum",  W'(tree_sum(bus.arr_out)), W'(1920));
    chk("full_ref_sum",   W'(bus.ref_sum), W'(SUM_EN ? 1920 : 0));
    tick();
    chk("full_in_ready_after",  W'(bus.in_ready), W'(1));
    chk("full_arr_valid_after", W'(bus.arr_valid), W'(0));

    // Back-to-back: frame A = k mod 16, frame B = all ones.
    idx = 0;
    nframes = 0;
    cyc_a = 0;
    cyc_b = 0;
    frame_a = '0;
    frame_b = '0;
    for (int cyc = 0; cyc < 600 && nframes < 2; cyc++) begin
      bus.in_valid = (idx < 2 * NIBBLES);
      bus.in_data  = (idx < NIBBLES) ? 4'(idx % 16) : 4'd1;
      rdy = bus.in_ready;
      tick();
      if (rdy && idx < 2 * NIBBLES) idx++;
      if (bus.arr_valid) begin
        if (nframes == 0) begin frame_a = bus.arr_out; cyc_a = cyc; end
        else begin frame_b = bus.arr_out; cyc_b = cyc; end
        nframes++;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_frames_seen", W'(nframes), W'(2));
    for (int k = 0; k < NIBBLES; k++) exp_arr[4*k +: 4] = 4'(k % 16);
    chk("b2b_frame_a",     frame_a, exp_arr);
    chk("b2b_sum_a",       W'(tree_sum(frame_a)), W'(960));
    for (int k = 0; k < NIBBLES; k++) exp_arr[4*k +: 4] = 4'd1;
    chk("b2b_frame_b",     frame_b, exp_arr);
    chk("b2b_sum_b",       W'(tree_sum(frame_b)), W'(128));
    chk("b2b_period",      W'(cyc_b - cyc_a), W'(129));
    tick();

    // Gapped input with in_last on the 128th operand.
    bus.arr_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 400 && !bus.arr_valid; cyc++) begin
      bus.in_valid = cyc[0];
      bus.in_data  = 4'((idx * 7 + 3) % 16);
      bus.in_last  = (idx == NIBBLES - 1);
      rdy = bus.in_ready;
      tick();
      if (rdy && bus.in_valid) idx++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    exp_sum = 0;
    for (int k = 0; k < NIBBLES; k++) begin
      exp_arr[4*k +: 4] = 4'((k * 7 + 3) % 16);
      exp_sum += (k * 7 + 3) % 16;
    end
    chk("gap_accepts",   W'(idx), W'(128));
    chk("gap_arr_valid", W'(bus.arr_valid), W'(1));
    chk("gap_arr_out",   bus.arr_out, exp_arr);
    chk("gap_fill_cnt",  W'(bus.fill_cnt), W'(128));
    chk("gap_tree_sum",  W'(tree_sum(bus.arr_out)), W'(exp_sum));
    chk("gap_ref_sum",   W'(bus.ref_sum), W'(SUM_EN ? exp_sum : 0));
    bus.arr_ready = 1'b1;
    tick();
    chk("gap_handoff_arr_valid", W'(bus.arr_valid), W'(0));
    chk("gap_handoff_arr_out",   bus.arr_out, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
